led_pattern_engine: RTL and testbench
=====================================

Name: led_pattern_engine

Overview:
- Parametrised multi-mode LED sequencer; successor to the fixed 8-LED, 1 Hz, single-pattern flasher.
- Integrates its own tick divider and drives an N_LED-wide LED bank directly from the board clock.
- Adds selectable pattern mode, selectable step rate and a pause control.
- Sits at board top level between the clock/reset pins and the LED pins.

Parameters:
- N_LED, 8, number of LEDs. Legal range is 2..16.
- DIV_BASE, 1500000, clock cycles per base tick. The default gives 8 Hz at 12 MHz.

Ports:
- clk  input  1  board clock
- rst  input  1  reset, synchronous, active-high
- mode  input  2  pattern select: 0 walk, 1 ping-pong, 2 binary count, 3 fill/drain
- speed  input  2  step rate: step period = 2^(3-speed) base ticks (0 = 1 Hz, 3 = 8 Hz at default)
- pause  input  1  1 = freeze divider and pattern
- led  output  N_LED  LED drive, active-high, registered
- step_pulse  output  1  one-cycle strobe, high in the same cycle led takes a new step value

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - rst has priority over all other inputs.
- Reset state:
  - led = 1 (bit0 set).
  - step_pulse = 0.
  - Internal mode register = 0, base counter = 0, sub counter = 0, direction = up, fill/drain state = FILL.
- Divider:
  - Base counter counts 0..DIV_BASE-1, then wraps.
  - A base tick occurs in the cycle the counter equals DIV_BASE-1.
  - Sub counter increments on each base tick.
  - A step fires on a base tick when sub >= 2^(3-speed)-1; sub then clears to 0.
  - The >= comparison means a speed change never stalls the sequence. It takes effect from the current sub value.
- Step timing:
  - led and step_pulse are both registered.
  - On the edge following a step condition, led takes its next value and step_pulse = 1 for exactly one cycle.
- Pause:
  - While pause = 1, the base counter, sub counter, led and pattern state all hold, and step_pulse = 0.
  - On release, counting resumes from the held values, so phase is preserved.
- Mode change:
  - A change is detected when the mode input differs from the internal mode register.
  - On the next edge: the mode register loads the new mode, the base and sub counters clear, direction = up, state = FILL, and step_pulse = 0.
  - led loads the start value: 1 for modes 0/1, 0 for modes 2/3.
  - Mode change has priority over pause and over a coincident step.
- Mode 0, walk:
  - led rotates left by one per step.
  - Bit N_LED-1 wraps to bit0.
- Mode 1, ping-pong:
  - Single lit LED moves up while direction = up.
  - At bit N_LED-1, direction flips and the next step moves down.
  - At bit0, direction flips back to up.
  - End positions are not repeated. Period = 2*(N_LED-1) steps.
  - For N_LED = 2 the sequence alternates 01, 10.
- Mode 2, binary count:
  - led increments by 1 per step, modulo 2^N_LED.
  - All-ones wraps to 0.
- Mode 3, fill/drain:
  - FILL state: led = (led<<1)|1 each step. On reaching all-ones, state becomes DRAIN.
  - DRAIN state: led = led>>1 each step. On reaching 0, state becomes FILL.
  - Period = 2*N_LED steps.
- Width rules: all shifts and increments are truncated to N_LED bits, with no overflow flag.

Test Plan:
All scenarios use N_LED=4 and DIV_BASE=4.
1. Walk: speed=3, mode=0, release rst.
   -> led=0001 at reset.
   -> step_pulse every 4 clk.
   -> led sequence 0010, 0100, 1000, 0001.
2. Ping-pong: mode=1, speed=3.
   -> led 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
   -> No repeated endpoints.
3. Binary: mode=2, speed=0.
   -> step every 32 clk.
   -> led 0000 through 1111, then 0000.
   -> Exactly 16 step_pulses in 512 clk.
4. Fill/drain: mode=3, speed=3.
   -> led 0000, 0001, 0011, 0111, 1111, 0111, 0011, 0001, 0000, 0001.
5. Pause: assert pause for 10 clk, 2 clk before a step is due.
   -> led and step_pulse frozen.
   -> The step arrives exactly 2 clk after release.
   -> Change speed 0->3 with sub=5: a step fires on the next base tick.
6. Mode change mid-sequence: in mode 0 with led=0100, set mode=2.
   -> Next edge: led=0000, counters cleared, step_pulse=0.
   -> First increment 4 clk later at speed 3.
   -> Separately, assert rst for 1 cycle mid-run: led=0001 and all counters 0 on the following edge.

Source files
------------

// File: rtl/led_pattern_engine.sv
// Multi-mode LED sequencer with an integrated tick divider.
// Patterns: walk, ping-pong, binary count, fill/drain; selectable rate and pause.
module led_pattern_engine #(
  parameter int N_LED    = 8,
  parameter int DIV_BASE = 1500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [N_LED-1:0] led,
  output logic             step_pulse
);

  localparam int BW = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;
  localparam logic [BW-1:0]    BASE_MAX = BW'(DIV_BASE - 1);
  localparam logic [N_LED-1:0] LED_ONE  = N_LED'(1);
  localparam logic [N_LED-1:0] LED_ZERO = '0;
  localparam logic [N_LED-1:0] LED_ALL  = '1;

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} fd_state_e;

  logic [BW-1:0]    base_q, base_d;
  logic [2:0]       sub_q, sub_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_up_q, dir_up_d;
  fd_state_e        fd_q, fd_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             step_q, step_d;

  logic [2:0]       sub_thr;
  logic             base_tick;
  logic             step_due;
  logic [N_LED-1:0] pat_led;
  logic             pat_dir_up;
  fd_state_e        pat_fd;

  // Step period minus one, in base ticks, for the selected speed
  always_comb begin
    sub_thr = 3'd0;
    case (speed)
      2'd0:    sub_thr = 3'd7;
      2'd1:    sub_thr = 3'd3;
      2'd2:    sub_thr = 3'd1;
      2'd3:    sub_thr = 3'd0;
      default: sub_thr = 3'd0;
    endcase
  end

  // Next pattern value and pattern state for one step of the current mode
  always_comb begin
    pat_led    = led_q;
    pat_dir_up = dir_up_q;
    pat_fd     = fd_q;
    case (mode_q)
      2'd0: pat_led = {led_q[N_LED-2:0], led_q[N_LED-1]};
      2'd1: begin
        // Turn around at the ends so end positions are shown only once
        if (dir_up_q) begin
          if (led_q[N_LED-1]) begin
            pat_led    = led_q >> 1;
            pat_dir_up = 1'b0;
          end else begin
            pat_led = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            pat_led    = led_q << 1;
            pat_dir_up = 1'b1;
          end else begin
            pat_led = led_q >> 1;
          end
        end
      end
      2'd2: pat_led = led_q + LED_ONE;
      2'd3: begin
        if (fd_q == FILL) begin
          pat_led = (led_q << 1) | LED_ONE;
          if (pat_led == LED_ALL) begin
            pat_fd = DRAIN;
          end else begin
            pat_fd = FILL;
          end
        end else begin
          pat_led = led_q >> 1;
          if (pat_led == LED_ZERO) begin
            pat_fd = FILL;
          end else begin
            pat_fd = DRAIN;
          end
        end
      end
      default: pat_led = led_q;
    endcase
  end

  // Divider, mode-change handling and step sequencing
  always_comb begin
    base_d    = base_q;
    sub_d     = sub_q;
    mode_d    = mode_q;
    dir_up_d  = dir_up_q;
    fd_d      = fd_q;
    led_d     = led_q;
    step_d    = 1'b0;
    base_tick = (base_q == BASE_MAX);
    step_due  = base_tick && (sub_q >= sub_thr);
    if (mode != mode_q) begin
      mode_d   = mode;
      base_d   = '0;
      sub_d    = 3'd0;
      dir_up_d = 1'b1;
      fd_d     = FILL;
      led_d    = mode[1] ? LED_ZERO : LED_ONE;
    end else if (pause) begin
      step_d = 1'b0;
    end else begin
      base_d = base_tick ? '0 : base_q + BW'(1);
      if (step_due) begin
        sub_d    = 3'd0;
        led_d    = pat_led;
        dir_up_d = pat_dir_up;
        fd_d     = pat_fd;
        step_d   = 1'b1;
      end else if (base_tick) begin
        sub_d = sub_q + 3'd1;
      end else begin
        sub_d = sub_q;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      sub_q    <= 3'd0;
      mode_q   <= 2'd0;
      dir_up_q <= 1'b1;
      fd_q     <= FILL;
      led_q    <= LED_ONE;
      step_q   <= 1'b0;
    end else begin
      base_q   <= base_d;
      sub_q    <= sub_d;
      mode_q   <= mode_d;
      dir_up_q <= dir_up_d;
      fd_q     <= fd_d;
      led_q    <= led_d;
      step_q   <= step_d;
    end
  end

  assign led        = led_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed self-checking bench for led_pattern_engine with N_LED=4, DIV_BASE=4.
module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       pause;
  logic [3:0] led;
  logic       step_pulse;

  int tests = 0;
  int fails = 0;

  led_pattern_engine #(.N_LED(4), .DIV_BASE(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .speed(speed), .pause(pause),
    .led(led), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'd0; speed = 2'd3; pause = 1'b0;
    tick(); tick();
    tests++; if (led !== 4'b0001) begin fails++; $display("FAIL reset_led got %b want 0001", led); end
    tests++; if (step_pulse !== 1'b0) begin fails++; $display("FAIL reset_step got %b want 0", step_pulse); end
    rst = 1'b0;
  endtask

  task automatic test_walk();
    logic [3:0] exp_v [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      for (int k = 1; k <= 4; k++) begin
        tick();
        tests++;
        if (step_pulse !== (k == 4)) begin fails++; $display("FAIL walk_step i=%0d k=%0d got %b", i, k, step_pulse); end
        if (k == 4) begin
          tests++; if (led !== exp_v[i]) begin fails++; $display("FAIL walk_led i=%0d got %b want %b", i, led, exp_v[i]); end
        end
      end
    end
  endtask

  task automatic test_pingpong();
    logic [3:0] exp_v [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    mode = 2'd1; speed = 2'd3;
    tick();
    tests++; if (led !== 4'b0001 || step_pulse !== 1'b0) begin fails++; $display("FAIL pp_start got %b/%b want 0001/0", led, step_pulse); end
    for (int i = 0; i < 7; i++) begin
      for (int k = 1; k <= 4; k++) begin
        tick();
        tests++;
        if (step_pulse !== (k == 4)) begin fails++; $display("FAIL pp_step i=%0d k=%0d got %b", i, k, step_pulse); end
        if (k == 4) begin
          tests++; if (led !== exp_v[i]) begin fails++; $display("FAIL pp_led i=%0d got %b want %b", i, led, exp_v[i]); end
        end
      end
    end
  endtask

  task automatic test_binary();
    int cnt = 0;
    logic [3:0] want;
    mode = 2'd2; speed = 2'd0;
    tick();
    tests++; if (led !== 4'b0000 || step_pulse !== 1'b0) begin fails++; $display("FAIL bin_start got %b/%b want 0000/0", led, step_pulse); end
    for (int k = 1; k <= 512; k++) begin
      tick();
      if (step_pulse === 1'b1) cnt++;
      if (k % 32 == 0) begin
        want = 4'(k / 32);
        tests++;
        if (step_pulse !== 1'b1 || led !== want) begin fails++; $display("FAIL bin_step k=%0d got %b/%b want 1/%b", k, step_pulse, led, want); end
      end
    end
    tests++; if (cnt != 16) begin fails++; $display("FAIL bin_count got %0d want 16", cnt); end
  endtask

  task automatic test_filldrain();
    logic [3:0] exp_v [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b0001};
    mode = 2'd3; speed = 2'd3;
    tick();
    tests++; if (led !== 4'b0000) begin fails++; $display("FAIL fd_start got %b want 0000", led); end
    for (int i = 0; i < 9; i++) begin
      for (int k = 1; k <= 4; k++) begin
        tick();
        tests++;
        if (step_pulse !== (k == 4)) begin fails++; $display("FAIL fd_step i=%0d k=%0d got %b", i, k, step_pulse); end
        if (k == 4) begin
          tests++; if (led !== exp_v[i]) begin fails++; $display("FAIL fd_led i=%0d got %b want %b", i, led, exp_v[i]); end
        end
      end
    end
  endtask

  task automatic test_pause();
    mode = 2'd0; speed = 2'd3;
    tick();
    tick(); tick();
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      tests++;
      if (step_pulse !== 1'b0 || led !== 4'b0001) begin fails++; $display("FAIL pause_hold k=%0d got %b/%b want 0/0001", k, step_pulse, led); end
    end
    pause = 1'b0;
    tick();
    tests++; if (step_pulse !== 1'b0) begin fails++; $display("FAIL pause_early got %b want 0", step_pulse); end
    tick();
    tests++; if (step_pulse !== 1'b1 || led !== 4'b0010) begin fails++; $display("FAIL pause_resume got %b/%b want 1/0010", step_pulse, led); end
    speed = 2'd0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      tests++;
      if (step_pulse !== (k == 32)) begin fails++; $display("FAIL slow_step k=%0d got %b", k, step_pulse); end
    end
    tests++; if (led !== 4'b0100) begin fails++; $display("FAIL slow_led got %b want 0100", led); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      tests++;
      if (step_pulse !== 1'b0) begin fails++; $display("FAIL sub5_idle k=%0d got %b want 0", k, step_pulse); end
    end
    speed = 2'd3;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++;
      if (step_pulse !== (k == 4)) begin fails++; $display("FAIL speedup_step k=%0d got %b", k, step_pulse); end
    end
    tests++; if (led !== 4'b1000) begin fails++; $display("FAIL speedup_led got %b want 1000", led); end
  endtask

  task automatic test_mode_change();
    for (int k = 0; k < 12; k++) tick();
    tests++; if (led !== 4'b0100) begin fails++; $display("FAIL mc_pre got %b want 0100", led); end
    mode = 2'd2;
    tick();
    tests++; if (led !== 4'b0000 || step_pulse !== 1'b0) begin fails++; $display("FAIL mc_load got %b/%b want 0000/0", led, step_pulse); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++;
      if (step_pulse !== (k == 4)) begin fails++; $display("FAIL mc_step k=%0d got %b", k, step_pulse); end
    end
    tests++; if (led !== 4'b0001) begin fails++; $display("FAIL mc_inc got %b want 0001", led); end
    tick(); tick();
    rst = 1'b1; mode = 2'd0;
    tick();
    tests++; if (led !== 4'b0001 || step_pulse !== 1'b0) begin fails++; $display("FAIL midrst got %b/%b want 0001/0", led, step_pulse); end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++;
      if (step_pulse !== (k == 4)) begin fails++; $display("FAIL midrst_step k=%0d got %b", k, step_pulse); end
    end
    tests++; if (led !== 4'b0010) begin fails++; $display("FAIL midrst_led got %b want 0010", led); end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_pingpong();
    test_binary();
    test_filldrain();
    test_pause();
    test_mode_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
